// File: rtl/data_mem_if.sv
// ============================================================================
//  Module   : data_mem_if
//  Brief    : MEM-stage request/response bundle between decode/ALU and the
//             data-memory responder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_mem_if;
  logic        MemEnable;
  logic        MemWrite;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        data_valid;
  logic        stall;
  logic        misaligned;

  modport master (
    output MemEnable, MemWrite, addr, wdata,
    input  rdata, data_valid, stall, misaligned
  );

  modport slave (
    input  MemEnable, MemWrite, addr, wdata,
    output rdata, data_valid, stall, misaligned
  );
endinterface

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
//  Module   : data_mem_responder
//  Brief    : Fixed-latency 16-bit word data memory that stalls the pipeline
//             for the duration of each access and flags odd addresses.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  data_mem_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_cnt_init = 4'(LATENCY - 1);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [15:0]           r_req_addr;
  logic [15:0]           r_req_wdata;
  logic                  r_req_write;
  logic [15:0]           r_rdata;
  logic                  r_data_valid;
  logic                  r_misaligned;
  logic [15:0]           r_mem [0:(1 << DEPTH_LOG2) - 1];

  logic                  w_accept;
  logic                  w_access;
  logic [DEPTH_LOG2-1:0] w_word;
  logic                  w_unused;

  assign w_accept = (r_state == S_IDLE) && bus.MemEnable && !bus.addr[0];
  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
  // Upper bits alias onto the same words; bit 0 is always zero once accepted.
  assign w_word   = r_req_addr[DEPTH_LOG2:1];
  assign w_unused = ^{r_req_addr[15:DEPTH_LOG2+1], r_req_addr[0]};

  // Array is kept out of the reset domain; a reset during WAIT clears the
  // state asynchronously, so a pending store can never reach this edge.
  always_ff @(posedge clk) begin
    if (w_access && r_req_write) begin
      r_mem[w_word] <= r_req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_req_addr   <= 16'h0000;
      r_req_wdata  <= 16'h0000;
      r_req_write  <= 1'b0;
      r_rdata      <= 16'h0000;
      r_data_valid <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_misaligned <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.MemEnable) begin
            if (!bus.addr[0]) begin
              r_req_addr  <= bus.addr;
              r_req_wdata <= bus.wdata;
              r_req_write <= bus.MemWrite;
              r_cnt       <= c_cnt_init;
              r_state     <= S_WAIT;
            end else begin
              r_misaligned <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            if (!r_req_write) begin
              r_rdata <= r_mem[w_word];
            end
            r_data_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        // MemEnable is still high here but belongs to the completing access.
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.stall      = w_accept || (r_state == S_WAIT);
  assign bus.rdata      = r_rdata;
  assign bus.data_valid = r_data_valid;
  assign bus.misaligned = r_misaligned;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
//  Module   : tb_data_mem_responder
//  Brief    : Directed self-checking bench for data_mem_responder (LATENCY=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  data_mem_if bus();

  data_mem_responder #(.LATENCY(4), .DEPTH_LOG2(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time=%0t)", $time);
    $fatal(1);
  end

  // Stimulus only: issue one request and hold it until its response cycle.
  task automatic do_access(input logic we, input logic [15:0] a,
                           input logic [15:0] d, output bit timeout);
    @(posedge clk); #1;
    bus.MemEnable = 1'b1; bus.MemWrite = we; bus.addr = a; bus.wdata = d;
    timeout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.data_valid === 1'b1) begin
        timeout = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    bus.MemEnable = 1'b0; bus.MemWrite = 1'b0;
  endtask

  task automatic test_reset();
    bus.MemEnable = 1'b0; bus.MemWrite = 1'b0; bus.addr = 16'h0; bus.wdata = 16'h0;
    rst_n = 1'b1;
    @(posedge clk); #3 rst_n = 1'b0; #1;
    checks++;
    if (bus.rdata !== 16'h0 || bus.data_valid !== 1'b0 || bus.misaligned !== 1'b0 || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: rdata=%h dv=%b mis=%b stall=%b, required 0000 0 0 0",
               bus.rdata, bus.data_valid, bus.misaligned, bus.stall);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    bus.MemWrite = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0 || bus.data_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_cycle%0d: stall=%b dv=%b, required 0 0", c, bus.stall, bus.data_valid);
      end
    end
    bus.MemWrite = 1'b0;
  endtask

  task automatic test_store_load();
    logic        exp_stall, exp_dv;
    logic [15:0] exp_rdata;
    @(posedge clk); #1;
    bus.MemEnable = 1'b1; bus.MemWrite = 1'b1; bus.addr = 16'h0010; bus.wdata = 16'hBEEF;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_stall = (c <= 4);
      exp_dv    = (c == 5);
      checks++;
      if (bus.stall !== exp_stall || bus.data_valid !== exp_dv || bus.rdata !== 16'h0000) begin
        failures++;
        $display("FAIL sw_cycle%0d: stall=%b dv=%b rdata=%h, required %b %b 0000",
                 c, bus.stall, bus.data_valid, bus.rdata, exp_stall, exp_dv);
      end
      @(posedge clk); #1;
      if (c == 5) bus.MemEnable = 1'b0;
    end
    bus.MemEnable = 1'b1; bus.MemWrite = 1'b0; bus.addr = 16'h0010; bus.wdata = 16'h0000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_stall = (c <= 4);
      exp_dv    = (c == 5);
      exp_rdata = (c >= 5) ? 16'hBEEF : 16'h0000;
      checks++;
      if (bus.stall !== exp_stall || bus.data_valid !== exp_dv || bus.rdata !== exp_rdata) begin
        failures++;
        $display("FAIL lw_cycle%0d: stall=%b dv=%b rdata=%h, required %b %b %h",
                 c, bus.stall, bus.data_valid, bus.rdata, exp_stall, exp_dv, exp_rdata);
      end
      @(posedge clk); #1;
      if (c == 5) bus.MemEnable = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    bit   to;
    int   dv_count;
    logic exp_stall, exp_dv;
    do_access(1'b1, 16'h0002, 16'h1111, to);
    checks++;
    if (to) begin failures++; $display("FAIL b2b_prep1: timeout=1, required 0"); end
    do_access(1'b1, 16'h0004, 16'h2222, to);
    checks++;
    if (to) begin failures++; $display("FAIL b2b_prep2: timeout=1, required 0"); end
    dv_count = 0;
    @(posedge clk); #1;
    bus.MemEnable = 1'b1; bus.MemWrite = 1'b0; bus.addr = 16'h0002;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      exp_stall = (c <= 4) || (c >= 6 && c <= 10);
      exp_dv    = (c == 5) || (c == 11);
      if (bus.data_valid === 1'b1) dv_count++;
      checks++;
      if (bus.stall !== exp_stall || bus.data_valid !== exp_dv) begin
        failures++;
        $display("FAIL b2b_cycle%0d: stall=%b dv=%b, required %b %b",
                 c, bus.stall, bus.data_valid, exp_stall, exp_dv);
      end
      if (c == 5 || c == 11) begin
        checks++;
        if (bus.rdata !== ((c == 5) ? 16'h1111 : 16'h2222)) begin
          failures++;
          $display("FAIL b2b_rdata_cycle%0d: rdata=%h, required %h",
                   c, bus.rdata, (c == 5) ? 16'h1111 : 16'h2222);
        end
      end
      @(posedge clk); #1;
      if (c == 5)  bus.addr = 16'h0004;
      if (c == 11) bus.MemEnable = 1'b0;
    end
    checks++;
    if (dv_count != 2) begin
      failures++;
      $display("FAIL b2b_pulses: count=%0d, required 2", dv_count);
    end
  endtask

  task automatic test_misaligned();
    @(posedge clk); #1;
    bus.MemEnable = 1'b1; bus.MemWrite = 1'b0; bus.addr = 16'h0003;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0 || bus.data_valid !== 1'b0 ||
          bus.misaligned !== (c == 1) || bus.rdata !== 16'h2222) begin
        failures++;
        $display("FAIL misaligned_cycle%0d: stall=%b dv=%b mis=%b rdata=%h, required 0 0 %b 2222",
                 c, bus.stall, bus.data_valid, bus.misaligned, bus.rdata, (c == 1));
      end
      @(posedge clk); #1;
      if (c == 0) bus.MemEnable = 1'b0;
    end
  endtask

  task automatic test_reset_mid_store();
    bit to;
    do_access(1'b1, 16'h0020, 16'h7777, to);
    checks++;
    if (to) begin failures++; $display("FAIL rst_prep: timeout=1, required 0"); end
    @(posedge clk); #1;
    bus.MemEnable = 1'b1; bus.MemWrite = 1'b1; bus.addr = 16'h0020; bus.wdata = 16'h1234;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b1) begin
      failures++;
      $display("FAIL rst_wait_stall: stall=%b, required 1", bus.stall);
    end
    @(posedge clk); #3;
    rst_n = 1'b0; bus.MemEnable = 1'b0; bus.MemWrite = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.data_valid !== 1'b0 || bus.rdata !== 16'h0000) begin
      failures++;
      $display("FAIL rst_mid_store: stall=%b dv=%b rdata=%h, required 0 0 0000",
               bus.stall, bus.data_valid, bus.rdata);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    do_access(1'b0, 16'h0020, 16'h0000, to);
    checks++;
    if (to || bus.rdata !== 16'h7777) begin
      failures++;
      $display("FAIL rst_aborted_store: timeout=%b rdata=%h, required 0 7777", to, bus.rdata);
    end
  endtask

  task automatic test_alias_and_stability();
    bit to;
    do_access(1'b1, 16'h0800, 16'h5A5A, to);
    do_access(1'b0, 16'h0000, 16'h0000, to);
    checks++;
    if (to || bus.rdata !== 16'h5A5A) begin
      failures++;
      $display("FAIL alias: timeout=%b rdata=%h, required 0 5a5a", to, bus.rdata);
    end
    do_access(1'b1, 16'h0040, 16'hAAAA, to);
    do_access(1'b1, 16'h0042, 16'h5555, to);
    @(posedge clk); #1;
    bus.MemEnable = 1'b1; bus.MemWrite = 1'b0; bus.addr = 16'h0040; bus.wdata = 16'h0000;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++;
      if (bus.data_valid !== (c == 5) || (c >= 5 && bus.rdata !== 16'hAAAA)) begin
        failures++;
        $display("FAIL stable_cycle%0d: dv=%b rdata=%h, required %b aaaa",
                 c, bus.data_valid, bus.rdata, (c == 5));
      end
      @(posedge clk); #1;
      if (c == 0) begin bus.addr = 16'h0042; bus.MemWrite = 1'b1; bus.wdata = 16'hFFFF; end
      if (c == 2) bus.addr = 16'h0043;
      if (c == 5) begin bus.MemEnable = 1'b0; bus.MemWrite = 1'b0; end
    end
    do_access(1'b0, 16'h0042, 16'h0000, to);
    checks++;
    if (to || bus.rdata !== 16'h5555) begin
      failures++;
      $display("FAIL stable_other_word: timeout=%b rdata=%h, required 0 5555", to, bus.rdata);
    end
    do_access(1'b0, 16'h0040, 16'h0000, to);
    checks++;
    if (to || bus.rdata !== 16'hAAAA) begin
      failures++;
      $display("FAIL stable_same_word: timeout=%b rdata=%h, required 0 aaaa", to, bus.rdata);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_misaligned();
    test_reset_mid_store();
    test_alias_and_stability();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
